// File: rtl/sweep_acq_controller.sv
// Sweep-acquisition sequencer: steps a 10-bit DAC code, reloads SC parameters and runs a fixed-length acquisition per point.
// Data words are forwarded one cycle after ParallelData_en, with no back-pressure; the header comes from the state, with no extra latency.
module sweep_acq_controller #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int RESET_CYCLES  = 4
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        SweepStartStop,
    input  logic [9:0]  StartDac,
    input  logic [9:0]  EndDac,
    input  logic [9:0]  DacStep,
    input  logic [15:0] MaxPackageNumber,
    output logic [9:0]  SweepAcq10BitDac,
    output logic        SweepAcqMicrorocSCParameterLoad,
    input  logic        SCParameterDone,
    output logic        SweepAcqMicrorocAcqStartStop,
    output logic        SweepAcqForceMicrorocAcqReset,
    input  logic [15:0] ParallelData,
    input  logic        ParallelData_en,
    output logic [15:0] SweepAcqData,
    output logic        SweepAcqData_en,
    output logic        SweepAcqDone
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_SC,
        S_WAIT_SC,
        S_SETTLE,
        S_HEADER,
        S_ACQ,
        S_RESET,
        S_NEXT,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] RESET_LAST  = 16'(RESET_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ss;
    logic        r_ss_d;
    logic [9:0]  r_dac;
    logic [9:0]  r_end;
    logic [9:0]  r_step;
    logic [15:0] r_max;
    logic [15:0] r_tmr;
    logic [15:0] r_words;
    logic [15:0] r_data;
    logic        r_data_en;

    logic        w_start;
    logic        w_busy;
    logic        w_abort;
    logic [9:0]  w_step_eff;
    logic [10:0] w_next_dac;
    logic        w_word_hit;
    logic        w_last_word;

    assign w_start     = r_ss & ~r_ss_d;
    assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ABORT);
    assign w_abort     = w_busy & ~r_ss;
    assign w_step_eff  = (r_step == 10'd0) ? 10'd1 : r_step;
    assign w_next_dac  = {1'b0, r_dac} + {1'b0, w_step_eff};
    assign w_word_hit  = (r_state == S_ACQ) && ParallelData_en;
    assign w_last_word = w_word_hit && ((r_words + 16'd1) == r_max);

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt                     = r_state;
        SweepAcq10BitDac                = r_dac;
        SweepAcqMicrorocSCParameterLoad = 1'b0;
        SweepAcqMicrorocAcqStartStop    = 1'b0;
        SweepAcqForceMicrorocAcqReset   = 1'b0;
        SweepAcqDone                    = 1'b0;
        SweepAcqData                    = r_data;
        SweepAcqData_en                 = r_data_en;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_LOAD_SC;
            end
            S_LOAD_SC: begin
                SweepAcqMicrorocSCParameterLoad = 1'b1;
                w_state_nxt                     = S_WAIT_SC;
            end
            S_WAIT_SC: begin
                if (SCParameterDone) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_tmr == SETTLE_LAST) w_state_nxt = S_HEADER;
            end
            S_HEADER: begin
                SweepAcqData    = {6'b111100, r_dac};
                SweepAcqData_en = 1'b1;
                w_state_nxt     = (r_max == 16'd0) ? S_RESET : S_ACQ;
            end
            S_ACQ: begin
                SweepAcqMicrorocAcqStartStop = 1'b1;
                if (w_last_word) w_state_nxt = S_RESET;
            end
            S_RESET: begin
                SweepAcqForceMicrorocAcqReset = 1'b1;
                if (r_tmr == RESET_LAST) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                // Bit 10 catches a step that carries past 1023 instead of wrapping to a low code
                if (w_next_dac[10] || (w_next_dac[9:0] > r_end)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_LOAD_SC;
                end
            end
            S_DONE: begin
                SweepAcqDone = 1'b1;
                if (!r_ss) w_state_nxt = S_IDLE;
            end
            S_ABORT: begin
                SweepAcqForceMicrorocAcqReset = 1'b1;
                if (r_tmr == RESET_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_ABORT;
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            // Sync history starts high so a level already held through reset is not seen as a new start
            r_ss      <= 1'b1;
            r_ss_d    <= 1'b1;
            r_dac     <= '0;
            r_end     <= '0;
            r_step    <= '0;
            r_max     <= '0;
            r_tmr     <= '0;
            r_words   <= '0;
            r_data    <= '0;
            r_data_en <= 1'b0;
        end else begin
            r_ss      <= SweepStartStop;
            r_ss_d    <= r_ss;
            r_tmr     <= (w_state_nxt != r_state) ? 16'd0 : r_tmr + 16'd1;
            r_data_en <= w_word_hit;
            r_data    <= w_word_hit ? ParallelData : 16'd0;
            if (r_state == S_HEADER) begin
                r_words <= '0;
            end else if (w_word_hit) begin
                r_words <= r_words + 16'd1;
            end
            if ((r_state == S_IDLE) && w_start) begin
                r_dac  <= StartDac;
                r_end  <= EndDac;
                r_step <= DacStep;
                r_max  <= MaxPackageNumber;
            end else if ((r_state == S_NEXT) && (w_state_nxt == S_LOAD_SC)) begin
                r_dac <= w_next_dac[9:0];
            end else if (w_state_nxt == S_IDLE) begin
                r_dac <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sweep_acq_controller.sv
// Randomized bench for sweep_acq_controller: logs DUT activity per cycle and checks it against
// a point list and timing expectations computed from the sweep rules.
module tb_sweep_acq_controller;
    localparam int S    = 8;
    localparam int R    = 4;
    localparam int HMAX = 65536;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        SweepStartStop;
    logic [9:0]  StartDac;
    logic [9:0]  EndDac;
    logic [9:0]  DacStep;
    logic [15:0] MaxPackageNumber;
    logic [9:0]  SweepAcq10BitDac;
    logic        SweepAcqMicrorocSCParameterLoad;
    logic        SCParameterDone;
    logic        SweepAcqMicrorocAcqStartStop;
    logic        SweepAcqForceMicrorocAcqReset;
    logic [15:0] ParallelData;
    logic        ParallelData_en;
    logic [15:0] SweepAcqData;
    logic        SweepAcqData_en;
    logic        SweepAcqDone;

    always #5 Clk = ~Clk;

    sweep_acq_controller #(.SETTLE_CYCLES(S), .RESET_CYCLES(R)) u_dut (
        .Clk                             (Clk),
        .reset_n                         (reset_n),
        .SweepStartStop                  (SweepStartStop),
        .StartDac                        (StartDac),
        .EndDac                          (EndDac),
        .DacStep                         (DacStep),
        .MaxPackageNumber                (MaxPackageNumber),
        .SweepAcq10BitDac                (SweepAcq10BitDac),
        .SweepAcqMicrorocSCParameterLoad (SweepAcqMicrorocSCParameterLoad),
        .SCParameterDone                 (SCParameterDone),
        .SweepAcqMicrorocAcqStartStop    (SweepAcqMicrorocAcqStartStop),
        .SweepAcqForceMicrorocAcqReset   (SweepAcqForceMicrorocAcqReset),
        .ParallelData                    (ParallelData),
        .ParallelData_en                 (ParallelData_en),
        .SweepAcqData                    (SweepAcqData),
        .SweepAcqData_en                 (SweepAcqData_en),
        .SweepAcqDone                    (SweepAcqDone)
    );

    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    string cur_test = "init";

    int load_q[$], dacl_q[$], scd_q[$], pres_c[$], pres_d[$], out_c[$], out_d[$];
    bit ss_h [HMAX];
    bit fr_h [HMAX];
    bit done_h [HMAX];
    int bad_idle = 0;
    int sc_due = -1;
    bit src_on = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Cycle index c here means: outputs of cycle c, inputs driven for cycle c
    always @(negedge Clk) begin
        if (cyc < HMAX) begin
            ss_h[cyc]   = SweepAcqMicrorocAcqStartStop;
            fr_h[cyc]   = SweepAcqForceMicrorocAcqReset;
            done_h[cyc] = SweepAcqDone;
        end
        if (SweepAcqData_en) begin
            out_c.push_back(cyc);
            out_d.push_back(int'(SweepAcqData));
        end else if (SweepAcqData != 16'd0) begin
            bad_idle++;
        end
        if (SweepAcqMicrorocSCParameterLoad) begin
            load_q.push_back(cyc);
            dacl_q.push_back(int'(SweepAcq10BitDac));
            sc_due = cyc + int'($urandom_range(1, 4));
        end
        if (cyc == sc_due) begin
            SCParameterDone = 1'b1;
            scd_q.push_back(cyc);
        end else begin
            SCParameterDone = 1'b0;
        end
        if (src_on && ($urandom_range(0, 2) != 0)) begin
            ParallelData_en = 1'b1;
            ParallelData    = 16'($urandom);
            pres_c.push_back(cyc);
            pres_d.push_back(int'(ParallelData));
        end else begin
            ParallelData_en = 1'b0;
            ParallelData    = 16'd0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0d (0x%0h) expected %0d (0x%0h)", cur_test, tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int count_win(input int sel, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            if (i >= 0 && i < HMAX) begin
                n += (sel == 0) ? int'(ss_h[i]) : (sel == 1) ? int'(fr_h[i]) : int'(done_h[i]);
            end
        end
        return n;
    endfunction

    task automatic clear_logs();
        load_q.delete(); dacl_q.delete(); scd_q.delete();
        pres_c.delete(); pres_d.delete(); out_c.delete(); out_d.delete();
        bad_idle = 0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_dac"},   int'(SweepAcq10BitDac), 0);
        chk({pfx, "_load"},  int'(SweepAcqMicrorocSCParameterLoad), 0);
        chk({pfx, "_ss"},    int'(SweepAcqMicrorocAcqStartStop), 0);
        chk({pfx, "_fr"},    int'(SweepAcqForceMicrorocAcqReset), 0);
        chk({pfx, "_data"},  int'(SweepAcqData), 0);
        chk({pfx, "_en"},    int'(SweepAcqData_en), 0);
        chk({pfx, "_done"},  int'(SweepAcqDone), 0);
    endtask

    task automatic run_sweep(input string name, input int sd, input int ed, input int st, input int mx);
        int pts[$];
        int d, n, sts, c0, hdr, k, pi, oi, done_cyc, exp_nxt;
        cur_test = name;
        sts = (st == 0) ? 1 : st;
        d = sd;
        while (1) begin
            pts.push_back(d);
            n = d + sts;
            if (n > ed || n > 1023) break;
            d = n;
        end
        StartDac = 10'(sd); EndDac = 10'(ed); DacStep = 10'(st); MaxPackageNumber = 16'(mx);
        @(negedge Clk);
        clear_logs();
        src_on = 1'b1;
        c0 = cyc;
        SweepStartStop = 1'b1;
        done_cyc = -1;
        for (int t = 0; t < 6000; t++) begin
            @(negedge Clk);
            if (SweepAcqDone) begin
                done_cyc = cyc;
                break;
            end
        end
        chk("done_seen", int'(done_cyc >= 0), 1);
        src_on = 1'b0;
        SweepStartStop = 1'b0;
        repeat (4) @(negedge Clk);
        chk("idle_dac", int'(SweepAcq10BitDac), 0);
        chk("idle_done", int'(SweepAcqDone), 0);
        chk("n_loads", load_q.size(), pts.size());
        chk("start_lat", (load_q.size() > 0) ? load_q[0] : -1, c0 + 2);
        pi = 0;
        oi = 0;
        for (int i = 0; i < pts.size() && i < scd_q.size() && i < load_q.size(); i++) begin
            chk("point_dac", dacl_q[i], pts[i]);
            hdr = scd_q[i] + S + 1;
            chk("hdr_cyc", (oi < out_c.size()) ? out_c[oi] : -1, hdr);
            chk("hdr_val", (oi < out_d.size()) ? out_d[oi] : -1, 32'hF000 | pts[i]);
            oi++;
            while (pi < pres_c.size() && pres_c[pi] <= hdr) pi++;
            k = hdr;
            for (int j = 0; j < mx && pi < pres_c.size(); j++) begin
                chk("word_cyc", (oi < out_c.size()) ? out_c[oi] : -1, pres_c[pi] + 1);
                chk("word_val", (oi < out_d.size()) ? out_d[oi] : -1, pres_d[pi]);
                k = pres_c[pi];
                pi++;
                oi++;
            end
            chk("ss_cycles", count_win(0, hdr + 1, k + R + 1), k - hdr);
            chk("fr_cycles", count_win(1, hdr + 1, k + R + 1), R);
            chk("fr_start", int'(fr_h[k + 1]), 1);
            exp_nxt = k + R + 2;
            if (i + 1 < pts.size()) begin
                chk("next_load", (i + 1 < load_q.size()) ? load_q[i + 1] : -1, exp_nxt);
            end else begin
                chk("done_cyc", done_cyc, exp_nxt);
            end
        end
        chk("n_usb_words", out_c.size(), oi);
        chk("idle_bus_zero", bad_idle, 0);
    endtask

    task automatic run_abort();
        int c, hdr, nexp, oi, t;
        cur_test = "abort_mid_acq";
        StartDac = 10'd200; EndDac = 10'd210; DacStep = 10'd1; MaxPackageNumber = 16'd5;
        @(negedge Clk);
        clear_logs();
        src_on = 1'b1;
        SweepStartStop = 1'b1;
        t = 0;
        while (out_c.size() < 2 && t < 500) begin
            @(negedge Clk);
            t++;
        end
        chk("reach_acq", int'(out_c.size() >= 2), 1);
        c = cyc;
        SweepStartStop = 1'b0;
        repeat (R + 6) @(negedge Clk);
        src_on = 1'b0;
        hdr = (scd_q.size() > 0) ? scd_q[0] + S + 1 : -1;
        chk("hdr_cyc", (out_c.size() > 0) ? out_c[0] : -1, hdr);
        oi = 1;
        nexp = 0;
        for (int p = 0; p < pres_c.size(); p++) begin
            if (pres_c[p] > hdr && pres_c[p] <= c + 1 && nexp < 5) begin
                chk("fwd_cyc", (oi < out_c.size()) ? out_c[oi] : -1, pres_c[p] + 1);
                chk("fwd_val", (oi < out_d.size()) ? out_d[oi] : -1, pres_d[p]);
                oi++;
                nexp++;
            end
        end
        chk("n_usb_words", out_c.size(), 1 + nexp);
        chk("ss_at_detect", int'(ss_h[c + 1]), 1);
        chk("ss_after", int'(ss_h[c + 2]), 0);
        chk("fr_first", int'(fr_h[c + 2]), 1);
        chk("fr_cycles", count_win(1, c + 2, c + R + 6), R);
        chk("no_done", count_win(2, c, c + R + 6), 0);
        chk("n_loads", load_q.size(), 1);
        chk("idle_dac", int'(SweepAcq10BitDac), 0);
    endtask

    task automatic run_reset_mid_settle();
        int t;
        cur_test = "reset_mid_settle";
        StartDac = 10'd300; EndDac = 10'd305; DacStep = 10'd1; MaxPackageNumber = 16'd2;
        @(negedge Clk);
        clear_logs();
        src_on = 1'b1;
        SweepStartStop = 1'b1;
        t = 0;
        while (scd_q.size() < 1 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("sc_done_seen", scd_q.size(), 1);
        repeat (3) @(negedge Clk);
        reset_n = 1'b0;
        @(negedge Clk);
        chk_all_zero("after_rst");
        reset_n = 1'b1;
        repeat (40) @(negedge Clk);
        chk("no_retrigger", load_q.size(), 1);
        chk("no_words", out_c.size(), 0);
        src_on = 1'b0;
        SweepStartStop = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        int sd, ed, st, mx;
        reset_n = 1'b0;
        SweepStartStop = 1'b0;
        StartDac = '0; EndDac = '0; DacStep = '0; MaxPackageNumber = '0;
        SCParameterDone = 1'b0;
        ParallelData = '0;
        ParallelData_en = 1'b0;
        repeat (3) @(negedge Clk);
        cur_test = "power_on_reset";
        chk_all_zero("rst");
        reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        run_sweep("basic_100_102", 100, 102, 1, 3);
        run_sweep("top_code_step0", 1023, 1023, 0, 2);
        run_sweep("step16_overrun", 1000, 1023, 16, 2);
        run_sweep("max_zero", 50, 53, 2, 0);
        run_sweep("start_gt_end", 700, 20, 3, 1);
        run_abort();
        run_sweep("restart_after_abort", 200, 201, 1, 2);
        run_reset_mid_settle();
        run_sweep("after_reset", 10, 12, 1, 2);

        for (int r = 0; r < 5; r++) begin
            sd = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) begin
                ed = int'($urandom_range(0, sd));
            end else begin
                ed = sd + int'($urandom_range(0, 30));
                if (ed > 1023) ed = 1023;
            end
            st = int'($urandom_range(0, 15));
            mx = int'($urandom_range(0, 4));
            run_sweep($sformatf("random_%0d", r), sd, ed, st, mx);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sweep_acq_controller.md
# sweep_acq_controller

Sequencer for sweep-acquisition mode. It steps one 10-bit DAC threshold from a start value to an end value and reloads the slow-control (SC) parameters at each point. At each point it runs a fixed-length Microroc acquisition, forwarding the acquired words to the USB FIFO path behind a per-point header. It drives the sweep-side inputs of the mode switcher (DAC value, SC load, acquisition start/stop, forced reset, USB data, done) and consumes the switcher's parallel data copy of the Microroc acquisition stream.

## Interface
Parameters:
- SETTLE_CYCLES, 1000: wait after SC load completes before the header is emitted (DAC settling); 16-bit counter.
- RESET_CYCLES, 4: width of the forced acquisition-reset pulse after each point or abort.

Ports:
- Clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- SweepStartStop  in  1  level. Rising edge starts a sweep; low in any busy state aborts it.
- StartDac  in  10  first DAC code.
- EndDac  in  10  last DAC code, inclusive.
- DacStep  in  10  increment per point; 0 is treated as 1.
- MaxPackageNumber  in  16  data words to collect per point.
- SweepAcq10BitDac  out  10  DAC code for the current point.
- SweepAcqMicrorocSCParameterLoad  out  1  one-cycle SC load request.
- SCParameterDone  in  1  one-cycle pulse: SC shift-in finished.
- SweepAcqMicrorocAcqStartStop  out  1  Microroc acquisition enable.
- SweepAcqForceMicrorocAcqReset  out  1  forced acquisition reset.
- ParallelData  in  16  Microroc acquisition word.
- ParallelData_en  in  1  ParallelData valid.
- SweepAcqData  out  16  word to the USB FIFO.
- SweepAcqData_en  out  1  SweepAcqData valid.
- SweepAcqDone  out  1  level: sweep completed normally.

## Operation
- Start detection:
  - SweepStartStop is registered once; a start is the previous sample 0 and the current sample 1.
  - A start is honoured only in IDLE.
- States: IDLE, LOAD_SC, WAIT_SC, SETTLE, HEADER, ACQ, RESET, NEXT, DONE, ABORT.
- IDLE: all outputs 0. On start, latch StartDac into the DAC register, capture the other inputs, then go to LOAD_SC.
- LOAD_SC: SweepAcqMicrorocSCParameterLoad=1 for exactly 1 cycle, then WAIT_SC.
- WAIT_SC: hold until SCParameterDone=1, then SETTLE. There is no timeout.
- SETTLE: count SETTLE_CYCLES cycles, then HEADER.
- HEADER: one cycle with SweepAcqData={6'b111100, dac}, en=1. Clear the word counter, then go to ACQ. If MaxPackageNumber==0, skip ACQ and go to RESET.
- ACQ:
  - SweepAcqMicrorocAcqStartStop=1.
  - Each ParallelData_en word is registered and output one cycle later on SweepAcqData/en, and the counter increments.
  - When the counter reaches MaxPackageNumber, go to RESET. The last counted word is still forwarded.
- RESET:
  - StartStop=0 and ForceMicrorocAcqReset=1 for RESET_CYCLES cycles.
  - ParallelData_en is ignored; those words are not forwarded.
  - Then go to NEXT.
- NEXT:
  - Compute next = {1'b0,dac} + step (11-bit).
  - If next > EndDac or next[10]=1, go to DONE; otherwise dac = next[9:0] and go to LOAD_SC.
  - StartDac > EndDac therefore runs a single point at StartDac.
- DONE: SweepAcqDone=1, held until SweepStartStop=0, then IDLE.
- ABORT:
  - Entered from any state except IDLE, DONE and ABORT when SweepStartStop=0.
  - StartStop=0, ForceReset=1 for RESET_CYCLES, no data forwarded, SweepAcqDone stays 0, then IDLE.
  - An abort in RESET restarts the reset count.
- SweepAcq10BitDac holds its value through DONE/ABORT and returns to 0 in IDLE.

## Timing
- Reset (reset_n=0 at a Clk edge): state IDLE; every output 0, including SweepAcq10BitDac, SweepAcqData and the counters.
- Start edge detected at cycle N (registered sample): LOAD_SC at N+1, SC load pulse at N+1, SweepAcq10BitDac valid from N+1.
- SCParameterDone at cycle M: SETTLE occupies M+1..M+SETTLE_CYCLES; header at M+SETTLE_CYCLES+1; StartStop high from the next cycle.
- Data latency: ParallelData_en at cycle K gives SweepAcqData_en at K+1. The maximum rate is one word per cycle with no back-pressure.
- Data bus is only driven with en=1; otherwise SweepAcqData=0.
- If the MaxPackageNumber-th word arrives at cycle K: StartStop falls at K+1, ForceReset is high K+1..K+RESET_CYCLES, and NEXT is at K+RESET_CYCLES+1.
- Abort in ACQ at cycle A (SweepStartStop low, registered): StartStop=0 from A+1. An en word at A is still forwarded at A+1; none after.

## Test plan
- Start=100, End=102, Step=1, Max=3, data bursts of 3:
  - 3 LOAD pulses; headers 16'hF064, F065, F066, each followed by 3 data words.
  - Done=1 after the third reset; total 12 USB words.
- Step=0, Start=End=1023: single point, header 16'hF3FF; no 11-bit overflow wrap to 0; Done asserted.
- Start=1000, End=1023, Step=16: points 1000 and 1016 only; next=1032>End ends the sweep.
- Max=0: header only per point, StartStop never asserted, ForceReset pulse of RESET_CYCLES each point.
- Drop SweepStartStop mid-ACQ after 1 of 5 words:
  - StartStop falls in 1 cycle, ForceReset 4 cycles, no further words forwarded, Done=0, returns to IDLE.
  - A new rising edge restarts from StartDac.
- reset_n low mid-SETTLE: next cycle all outputs 0, state IDLE; a start already held high does not retrigger without a new 0→1 edge.
